// File: rtl/fir_out_checker.sv
// Output sink for the FIR datapath: compares each valid sample against a preloaded
// golden table within a tolerance and reports counts, first mismatch and a verdict.
module fir_out_checker #(
  parameter int DW  = 16,
  parameter int AW  = 8,
  parameter int TOL = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EXP_WE,
  input  logic [AW-1:0] EXP_ADDR,
  input  logic [DW-1:0] EXP_DATA,
  input  logic [AW:0]   NSAMP,
  input  logic          START,
  input  logic          VIN,
  input  logic [DW-1:0] DIN,
  output logic          BUSY,
  output logic          DONE,
  output logic          PASS,
  output logic [AW:0]   SAMP_CNT,
  output logic [AW:0]   ERR_CNT,
  output logic [AW-1:0] FIRST_IDX,
  output logic [DW-1:0] FIRST_VAL,
  output logic          EXTRA
);

  // state | meaning
  // IDLE  | table writable, waiting for START
  // RUN   | accepting samples, compare stage active
  // FIN   | verdict held, table writable, VIN flags EXTRA
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [DW:0] TOL_W = (DW+1)'(TOL);

  state_t        state_q, state_d;
  logic [AW:0]   nsamp_q, nsamp_d;
  logic [AW:0]   samp_cnt_q, samp_cnt_d;
  logic [AW:0]   err_cnt_q, err_cnt_d;
  logic [AW-1:0] first_idx_q, first_idx_d;
  logic [DW-1:0] first_val_q, first_val_d;
  logic          extra_q, extra_d;
  logic          cmp_vld_q, cmp_vld_d;
  logic          cmp_last_q, cmp_last_d;
  logic [AW-1:0] cmp_idx_q, cmp_idx_d;
  logic [DW-1:0] cmp_din_q, cmp_din_d;
  logic [DW-1:0] exp_rd_q;
  logic [DW-1:0] mem [2**AW];

  logic          accept;
  logic [DW:0]   diff;
  logic [DW:0]   mag;
  logic          mismatch;

  assign accept = (state_q == RUN) && VIN && (samp_cnt_q != nsamp_q);

  // Differences are formed at DW+1 bits so full-scale opposite extremes never wrap.
  assign diff     = {cmp_din_q[DW-1], cmp_din_q} - {exp_rd_q[DW-1], exp_rd_q};
  assign mag      = diff[DW] ? (~diff + 1'b1) : diff;
  assign mismatch = mag > TOL_W;

  always_ff @(posedge CLK) begin
    if (EXP_WE && (state_q != RUN)) mem[EXP_ADDR] <= EXP_DATA;
    if (accept) exp_rd_q <= mem[samp_cnt_q[AW-1:0]];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      nsamp_q     <= '0;
      samp_cnt_q  <= '0;
      err_cnt_q   <= '0;
      first_idx_q <= '0;
      first_val_q <= '0;
      extra_q     <= 1'b0;
      cmp_vld_q   <= 1'b0;
      cmp_last_q  <= 1'b0;
      cmp_idx_q   <= '0;
      cmp_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      nsamp_q     <= nsamp_d;
      samp_cnt_q  <= samp_cnt_d;
      err_cnt_q   <= err_cnt_d;
      first_idx_q <= first_idx_d;
      first_val_q <= first_val_d;
      extra_q     <= extra_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_last_q  <= cmp_last_d;
      cmp_idx_q   <= cmp_idx_d;
      cmp_din_q   <= cmp_din_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    nsamp_d     = nsamp_q;
    samp_cnt_d  = samp_cnt_q;
    err_cnt_d   = err_cnt_q;
    first_idx_d = first_idx_q;
    first_val_d = first_val_q;
    extra_d     = extra_q;
    cmp_vld_d   = 1'b0;
    cmp_last_d  = cmp_last_q;
    cmp_idx_d   = cmp_idx_q;
    cmp_din_d   = cmp_din_q;

    if (cmp_vld_q) begin
      if (mismatch) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        if (err_cnt_q == '0) begin
          first_idx_d = cmp_idx_q;
          first_val_d = cmp_din_q;
        end
      end
      if (cmp_last_q) state_d = FIN;
    end

    case (state_q)
      IDLE, FIN: begin
        if (START) begin
          nsamp_d     = NSAMP;
          samp_cnt_d  = '0;
          err_cnt_d   = '0;
          first_idx_d = '0;
          first_val_d = '0;
          extra_d     = 1'b0;
          state_d     = (NSAMP == '0) ? FIN : RUN;
        end else if ((state_q == FIN) && VIN) begin
          extra_d = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          samp_cnt_d = samp_cnt_q + 1'b1;
          cmp_vld_d  = 1'b1;
          cmp_idx_d  = samp_cnt_q[AW-1:0];
          cmp_din_d  = DIN;
          cmp_last_d = (samp_cnt_q == nsamp_q - 1'b1);
        end else if (VIN) begin
          // All samples taken; this VIN lands in the cycle that enters FIN.
          extra_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign BUSY      = (state_q == RUN);
  assign DONE      = (state_q == FIN);
  assign PASS      = DONE && (err_cnt_q == '0) && !extra_q;
  assign SAMP_CNT  = samp_cnt_q;
  assign ERR_CNT   = err_cnt_q;
  assign FIRST_IDX = first_idx_q;
  assign FIRST_VAL = first_val_q;
  assign EXTRA     = extra_q;

endmodule

// File: tb/tb_fir_out_checker.sv
// Directed bench for fir_out_checker; two instances (TOL=0 and TOL=1) share stimulus.
module tb_fir_out_checker;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, exp_we, start, vin;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data, din;
  logic [AW:0]   nsamp;

  logic          b0, d0, p0, x0, b1, d1, p1, x1;
  logic [AW:0]   sc0, ec0, sc1, ec1;
  logic [AW-1:0] fi0, fi1;
  logic [DW-1:0] fv0, fv1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] gold [8];
  logic [DW-1:0] s    [8];

  always #5 clk = ~clk;

  fir_out_checker #(.DW(DW), .AW(AW), .TOL(0)) u_dut0 (
    .CLK(clk), .RST(rst), .EXP_WE(exp_we), .EXP_ADDR(exp_addr), .EXP_DATA(exp_data),
    .NSAMP(nsamp), .START(start), .VIN(vin), .DIN(din),
    .BUSY(b0), .DONE(d0), .PASS(p0), .SAMP_CNT(sc0), .ERR_CNT(ec0),
    .FIRST_IDX(fi0), .FIRST_VAL(fv0), .EXTRA(x0));

  fir_out_checker #(.DW(DW), .AW(AW), .TOL(1)) u_dut1 (
    .CLK(clk), .RST(rst), .EXP_WE(exp_we), .EXP_ADDR(exp_addr), .EXP_DATA(exp_data),
    .NSAMP(nsamp), .START(start), .VIN(vin), .DIN(din),
    .BUSY(b1), .DONE(d1), .PASS(p1), .SAMP_CNT(sc1), .ERR_CNT(ec1),
    .FIRST_IDX(fi1), .FIRST_VAL(fv1), .EXTRA(x1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [DW-1:0] v);
    exp_we = 1'b1; exp_addr = AW'(a); exp_data = v;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic start_run(input int n);
    start = 1'b1; nsamp = (AW+1)'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic stream8();
    for (int i = 0; i < 8; i++) begin
      vin = 1'b1; din = s[i];
      tick();
    end
    vin = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    vin = 1'b1; din = 16'h1234;
    tick(); tick();
    vin = 1'b0;
    n_tests++;
    if ({b0, d0, p0, x0, sc0, ec0, fi0, fv0} !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b pass=%b extra=%b samp=%0d err=%0d fidx=%0d fval=%h, all zero required",
               b0, d0, p0, x0, sc0, ec0, fi0, fv0);
    end
  endtask

  task automatic test_nsamp0();
    start_run(0);
    n_tests++;
    if (!(d0 === 1'b1 && p0 === 1'b1 && b0 === 1'b0)) begin
      n_fail++;
      $display("FAIL nsamp0: done=%b pass=%b busy=%b, required 1 1 0", d0, p0, b0);
    end
  endtask

  task automatic test_full_256();
    for (int i = 0; i < 256; i++) load(i, 16'(i));
    start_run(256);
    for (int i = 0; i < 256; i++) begin
      vin = 1'b1; din = 16'(i + 1000);
      tick();
    end
    vin = 1'b0;
    tick();
    n_tests++;
    if (!(ec0 === 9'd256 && ec1 === 9'd256 && sc0 === 9'd256)) begin
      n_fail++;
      $display("FAIL full256_cnt: err0=%0d err1=%0d samp=%0d, required 256 256 256", ec0, ec1, sc0);
    end
    n_tests++;
    if (!(d0 === 1'b1 && p0 === 1'b0 && fi0 === 8'd0 && fv0 === 16'd1000)) begin
      n_fail++;
      $display("FAIL full256_verdict: done=%b pass=%b fidx=%0d fval=%0d, required 1 0 0 1000", d0, p0, fi0, fv0);
    end
  endtask

  task automatic test_exact_pass();
    for (int i = 0; i < 8; i++) load(i, gold[i]);
    for (int i = 0; i < 8; i++) s[i] = gold[i];
    start_run(8);
    n_tests++;
    if (b0 !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: busy=%b, required 1", b0);
    end
    stream8();
    n_tests++;
    if (!(sc0 === 9'd8 && d0 === 1'b0 && b0 === 1'b1)) begin
      n_fail++;
      $display("FAIL last_edge: samp=%0d done=%b busy=%b, required 8 0 1", sc0, d0, b0);
    end
    tick();
    n_tests++;
    if (!(d0 === 1'b1 && p0 === 1'b1 && b0 === 1'b0 && ec0 === 9'd0)) begin
      n_fail++;
      $display("FAIL exact_pass: done=%b pass=%b busy=%b err=%0d, required 1 1 0 0", d0, p0, b0, ec0);
    end
  endtask

  task automatic test_mismatch();
    for (int i = 0; i < 8; i++) s[i] = gold[i];
    s[3] = 16'sd32766;
    s[6] = -16'sd4;
    start_run(8);
    for (int i = 0; i < 8; i++) begin
      vin = 1'b1; din = s[i];
      tick();
      if (i == 3) begin
        n_tests++;
        if (ec0 !== 9'd0) begin
          n_fail++;
          $display("FAIL err_latency_k: err=%0d, required 0", ec0);
        end
      end
      if (i == 4) begin
        n_tests++;
        if (ec0 !== 9'd1) begin
          n_fail++;
          $display("FAIL err_latency_k1: err=%0d, required 1", ec0);
        end
      end
    end
    vin = 1'b0;
    tick();
    n_tests++;
    if (!(ec0 === 9'd2 && fi0 === 8'd3 && fv0 === 16'h7FFE && p0 === 1'b0 && d0 === 1'b1)) begin
      n_fail++;
      $display("FAIL mismatch: err=%0d fidx=%0d fval=%h pass=%b done=%b, required 2 3 7ffe 0 1",
               ec0, fi0, fv0, p0, d0);
    end
  endtask

  task automatic test_tolerance();
    s[0] = 16'sd1;     s[1] = 16'sd99;    s[2] = -16'sd102; s[3] = 16'sd32766;
    s[4] = -16'sd32767; s[5] = 16'sd6;    s[6] = -16'sd6;   s[7] = 16'sd2;
    start_run(8);
    stream8();
    tick();
    n_tests++;
    if (!(ec1 === 9'd1 && fi1 === 8'd2 && fv1 === 16'hFF9A && p1 === 1'b0)) begin
      n_fail++;
      $display("FAIL tol1: err=%0d fidx=%0d fval=%h pass=%b, required 1 2 ff9a 0", ec1, fi1, fv1, p1);
    end
    n_tests++;
    if (!(ec0 === 9'd8 && fi0 === 8'd0 && fv0 === 16'd1)) begin
      n_fail++;
      $display("FAIL tol0_all: err=%0d fidx=%0d fval=%h, required 8 0 0001", ec0, fi0, fv0);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) s[i] = gold[i];
    s[4] = 16'sd32767;
    start_run(8);
    stream8();
    tick();
    n_tests++;
    if (!(ec1 === 9'd1 && fi1 === 8'd4 && fv1 === 16'h7FFF && d1 === 1'b1)) begin
      n_fail++;
      $display("FAIL wrap: err=%0d fidx=%0d fval=%h done=%b, required 1 4 7fff 1", ec1, fi1, fv1, d1);
    end
  endtask

  task automatic test_gapped_extra();
    logic [6:0] pat;
    int j;
    pat = 7'b1101001;
    j = 0;
    start_run(4);
    for (int i = 0; i < 7; i++) begin
      vin = pat[i];
      din = pat[i] ? gold[j] : 16'hDEAD;
      if (pat[i]) j++;
      tick();
    end
    vin = 1'b0;
    tick();
    n_tests++;
    if (!(d0 === 1'b1 && p0 === 1'b1 && sc0 === 9'd4 && x0 === 1'b0)) begin
      n_fail++;
      $display("FAIL gapped: done=%b pass=%b samp=%0d extra=%b, required 1 1 4 0", d0, p0, sc0, x0);
    end
    vin = 1'b1; din = gold[4];
    tick();
    vin = 1'b0;
    tick();
    n_tests++;
    if (!(x0 === 1'b1 && p0 === 1'b0 && sc0 === 9'd4 && d0 === 1'b1)) begin
      n_fail++;
      $display("FAIL extra: extra=%b pass=%b samp=%0d done=%b, required 1 0 4 1", x0, p0, sc0, d0);
    end
  endtask

  task automatic test_back_to_back_extra();
    // VIN in the cycle right after the last sample already counts as extra.
    for (int i = 0; i < 8; i++) s[i] = gold[i];
    start_run(8);
    stream8();
    vin = 1'b1; din = 16'h0;
    tick();
    vin = 1'b0;
    n_tests++;
    if (!(d0 === 1'b1 && x0 === 1'b1 && p0 === 1'b0 && sc0 === 9'd8)) begin
      n_fail++;
      $display("FAIL k1_extra: done=%b extra=%b pass=%b samp=%0d, required 1 1 0 8", d0, x0, p0, sc0);
    end
    // START with VIN from FIN: START wins and clears the sticky flag.
    vin = 1'b1;
    start_run(0);
    vin = 1'b0;
    n_tests++;
    if (!(x0 === 1'b0 && p0 === 1'b1 && d0 === 1'b1)) begin
      n_fail++;
      $display("FAIL start_wins: extra=%b pass=%b done=%b, required 0 1 1", x0, p0, d0);
    end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 8; i++) s[i] = gold[i];
    start_run(8);
    for (int i = 0; i < 3; i++) begin
      vin = 1'b1; din = 16'h5555;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; vin = 1'b0;
    n_tests++;
    if ({b0, d0, p0, x0, sc0, ec0, fi0, fv0} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: busy=%b done=%b pass=%b extra=%b samp=%0d err=%0d fidx=%0d fval=%h, all zero required",
               b0, d0, p0, x0, sc0, ec0, fi0, fv0);
    end
    tick();
    n_tests++;
    if (ec0 !== 9'd0) begin
      n_fail++;
      $display("FAIL rst_discard: err=%0d, required 0", ec0);
    end
    start_run(8);
    stream8();
    tick();
    n_tests++;
    if (!(d0 === 1'b1 && p0 === 1'b1 && sc0 === 9'd8 && ec0 === 9'd0)) begin
      n_fail++;
      $display("FAIL rst_rerun: done=%b pass=%b samp=%0d err=%0d, required 1 1 8 0", d0, p0, sc0, ec0);
    end
  endtask

  initial begin
    rst = 1'b1; exp_we = 1'b0; start = 1'b0; vin = 1'b0;
    exp_addr = '0; exp_data = '0; din = '0; nsamp = '0;
    gold[0] = 16'sd0;    gold[1] = 16'sd100; gold[2] = -16'sd100; gold[3] = 16'sd32767;
    gold[4] = 16'h8000;  gold[5] = 16'sd5;   gold[6] = -16'sd5;   gold[7] = 16'sd1;
    test_reset();
    test_nsamp0();
    test_full_256();
    test_exact_pass();
    test_mismatch();
    test_tolerance();
    test_wrap();
    test_gapped_extra();
    test_back_to_back_extra();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
